ntt_stage_ctrl: RTL
===================

# ntt_stage_ctrl

Sequencing controller for the Cooley-Tukey butterfly datapath in the NTT accelerator. On `start` it walks all LOG_N stages of an in-place forward NTT over an N = 2^LOG_N coefficient RAM. Each cycle it issues one butterfly's read addresses and twiddle-ROM address, and tracks every butterfly through the RAM-read plus butterfly pipeline so the write-back addresses line up with the butterfly outputs. It sits between the top-level host handshake and the coefficient RAM / twiddle ROM / `ct_butterfly` datapath.

## Interface
- `LOG_N`, 12, log2 of transform size; N/2 butterflies per stage.
- `BF_LATENCY`, 12, butterfly pipeline depth in cycles.
- `RD_LATENCY`, 1, coefficient-RAM and twiddle-ROM read latency in cycles.
- Derived: PIPE = RD_LATENCY + BF_LATENCY.

Ports:
- `clk  in  1`  clock. All logic is rising-edge.
- `rst_n  in  1`  asynchronous active-low reset.
- `start  in  1`  starts a transform. Sampled only in IDLE.
- `busy  out  1`  high from the first ISSUE cycle through the last DRAIN cycle.
- `done  out  1`  one-cycle pulse when the transform completes.
- `stage  out  5`  current stage index, 0..LOG_N-1.
- `rd_en  out  1`  read strobe for the RAM and ROM.
- `rd_addr_a  out  LOG_N`  RAM read address for butterfly input a.
- `rd_addr_b  out  LOG_N`  RAM read address for butterfly input b.
- `tw_addr  out  LOG_N`  twiddle-ROM address.
- `wr_en  out  1`  write-back strobe.
- `wr_addr_a  out  LOG_N`  write address for butterfly output A.
- `wr_addr_b  out  LOG_N`  write address for butterfly output B.

## Operation
- Reset values: all outputs 0. State is IDLE, stage=0, k=0, delay line all invalid.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE, `start`=1: go to ISSUE with stage=0, k=0.
  - ISSUE: each cycle assert `rd_en` and increment k. When k=N/2-1 is issued, go to DRAIN.
  - DRAIN: hold `rd_en`=0 for exactly PIPE cycles.
    - If stage<LOG_N-1: stage+1, k=0, return to ISSUE.
    - Otherwise go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `start` is ignored outside IDLE.
- Address generation for stage s with butterfly index k, where L = LOG_N-1-s:
  - i = k>>L, j = k & (2^L-1)
  - `rd_addr_a` = (i<<(L+1)) | j
  - `rd_addr_b` = `rd_addr_a` + 2^L
  - `tw_addr` = 2^s + i
  - All values are unsigned and fit in LOG_N bits. There is no wrap-around.
- Write tracking: a PIPE-deep delay line of {valid, addr_a, addr_b}. It shifts every cycle in every state. Its input is {rd_en, rd_addr_a, rd_addr_b}. The output drives `wr_en` and `wr_addr_*`.
- `rd_addr_*` and `tw_addr` are don't-care when `rd_en`=0.
- Hazard rule: the next stage's first read is issued one cycle after the previous stage's last write. The RAM must make that write visible to the read.
- Reset mid-transform: FSM returns to IDLE and the delay line clears immediately, so no further `wr_en` is produced. No `done` is generated.

## Timing
- `start` sampled high at edge 0 gives the first `rd_en` in cycle 1.
- `wr_en` for a read issued in cycle c occurs in cycle c+PIPE.
- Per stage: N/2 ISSUE cycles, then PIPE DRAIN cycles.
- `busy` lasts LOG_N·(N/2+PIPE) cycles. `done` pulses in the following cycle, with `busy`=0.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- `NTT_CTRL_STALL_EN` defined:
  - Adds input port `stall` (1 bit).
  - In ISSUE, `stall`=1 forces `rd_en`=0 and freezes k and stage. The delay line keeps shifting, so a bubble enters it.
  - `stall` has no effect in IDLE, DRAIN or DONE.
  - `busy` length grows by the number of stalled ISSUE cycles.
- Not defined: no `stall` port, and ISSUE is unconditional.

## Test plan
All scenarios use LOG_N=3, BF_LATENCY=2, RD_LATENCY=1, giving N=8 and PIPE=3.

- Stage 0 sequence: `start` -> (a,b,tw) over cycles 1-4 = (0,4,1) (1,5,1) (2,6,1) (3,7,1). `wr_en` in cycles 4-7 carries the same a/b pairs.
- Stages 1 and 2 sequence: stage 1 = (0,2,2) (1,3,2) (4,6,3) (5,7,3). Stage 2 = (0,1,4) (2,3,5) (4,5,6) (6,7,7). The first read of stage 1 is in cycle 8, one cycle after the last stage-0 write.
- Completion: `busy` is high in cycles 1-21 and `done` pulses in cycle 22. `start` held high through the run causes no restart. A fresh `start` in cycle 23 repeats the whole sequence.
- Reset mid-operation: `rst_n` low in cycle 10 -> all outputs 0 immediately and no `wr_en` afterwards. After release, `start` reproduces the reference sequence.
- Stall (macro defined): `stall` high in cycles 2-3 -> stage-0 reads in cycles 1, 4, 5, 6. `wr_en` in cycles 4, 7, 8, 9. `done` pulses in cycle 24.

Source files
------------

// File: rtl/ntt_stage_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 forward NTT with write-back tracking.
// Optional macro NTT_CTRL_STALL_EN adds a `stall` input that freezes issue for a cycle.
module ntt_stage_ctrl #(
  parameter int LOG_N      = 12,
  parameter int BF_LATENCY = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef NTT_CTRL_STALL_EN
  input  logic             stall,
`endif
  output logic             busy,
  output logic             done,
  output logic [4:0]       stage,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-1:0] tw_addr,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b
);

  localparam int PIPE = RD_LATENCY + BF_LATENCY;
  localparam int KW   = LOG_N - 1;
  localparam int CW   = (PIPE > 1) ? $clog2(PIPE) : 1;

  localparam logic [KW-1:0]    K_LAST     = {KW{1'b1}};
  localparam logic [CW-1:0]    CNT_LAST   = CW'(PIPE - 1);
  localparam logic [4:0]       STAGE_LAST = 5'(LOG_N - 1);
  localparam logic [LOG_N-1:0] ONE        = {{(LOG_N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [4:0]    r_stage, w_stage_nxt;
  logic [KW-1:0] r_k,     w_k_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic          w_stall;

`ifdef NTT_CTRL_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  // State, stage, butterfly index and drain counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_stage <= 5'd0;
      r_k     <= {KW{1'b0}};
      r_cnt   <= {CW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
      r_k     <= w_k_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic for the issue / drain sequence
  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_k_nxt     = r_k;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ISSUE;
          w_stage_nxt = 5'd0;
          w_k_nxt     = {KW{1'b0}};
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (w_stall) begin
          w_k_nxt = r_k;
        end else if (r_k == K_LAST) begin
          w_state_nxt = S_DRAIN;
          w_k_nxt     = {KW{1'b0}};
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_k_nxt = r_k + {{(KW-1){1'b0}}, 1'b1};
        end
      end
      S_DRAIN: begin
        // Leaving only after the last write-back keeps the next stage's reads hazard-free
        if (r_cnt == CNT_LAST) begin
          if (r_stage == STAGE_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ISSUE;
            w_stage_nxt = r_stage + 5'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  logic [4:0]       w_l;
  logic [LOG_N-1:0] w_k_ext, w_i, w_j, w_a, w_b, w_tw;

  // Butterfly pair address: span 2^L with L = LOG_N-1-stage
  always_comb begin
    w_l     = STAGE_LAST - r_stage;
    w_k_ext = {1'b0, r_k};
    w_i     = w_k_ext >> w_l;
    w_j     = w_k_ext & ((ONE << w_l) - ONE);
    w_a     = (w_i << (w_l + 5'd1)) | w_j;
    w_b     = w_a + (ONE << w_l);
    w_tw    = (ONE << r_stage) + w_i;
  end

  assign rd_en     = (r_state == S_ISSUE) && !w_stall;
  assign rd_addr_a = rd_en ? w_a  : {LOG_N{1'b0}};
  assign rd_addr_b = rd_en ? w_b  : {LOG_N{1'b0}};
  assign tw_addr   = rd_en ? w_tw : {LOG_N{1'b0}};
  assign busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign stage     = r_stage;

  logic             r_dl_vld [PIPE];
  logic [LOG_N-1:0] r_dl_a   [PIPE];
  logic [LOG_N-1:0] r_dl_b   [PIPE];

  // Write-back delay line matching RAM-read plus butterfly latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE; i++) begin
        r_dl_vld[i] <= 1'b0;
        r_dl_a[i]   <= {LOG_N{1'b0}};
        r_dl_b[i]   <= {LOG_N{1'b0}};
      end
    end else begin
      r_dl_vld[0] <= rd_en;
      r_dl_a[0]   <= rd_addr_a;
      r_dl_b[0]   <= rd_addr_b;
      for (int i = 1; i < PIPE; i++) begin
        r_dl_vld[i] <= r_dl_vld[i-1];
        r_dl_a[i]   <= r_dl_a[i-1];
        r_dl_b[i]   <= r_dl_b[i-1];
      end
    end
  end

  assign wr_en     = r_dl_vld[PIPE-1];
  assign wr_addr_a = r_dl_a[PIPE-1];
  assign wr_addr_b = r_dl_b[PIPE-1];

endmodule
